fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 Parameter MEM_BASE, default 32'h8000_0000: lowest legal fetch address.
REQ-003 Parameter MEM_WORDS, default 256: imem depth in 32-bit words; legal range is [MEM_BASE, MEM_BASE+4*MEM_WORDS).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 imem_addr  out  32  fetch address to the synchronous-read imem; imem data is returned one cycle later.
REQ-007 imem_data  in  32  instruction word for the address issued in the previous cycle.
REQ-008 redirect_valid  in  1  branch/jump redirect request.
REQ-009 redirect_pc  in  32  redirect target, valid while redirect_valid=1.
REQ-010 out_valid  out  1  instruction available to decode.
REQ-011 out_ready  in  1  decode accepts; transfer occurs when out_valid & out_ready.
REQ-012 out_pc  out  32  PC of the presented instruction.
REQ-013 out_instr  out  32  presented instruction word.
REQ-014 out_fault  out  1  presented entry is an illegal-address fetch.

Function
REQ-015 State: fetch_pc (32b), in-flight flag and PC (inflight_q, inflight_pc), 2-entry FIFO {pc, instr, fault}, count (0..2), and FSM with states RUN and HALT.
REQ-016 imem_addr SHALL equal fetch_pc combinationally at all times.
REQ-017 Issue condition: state==RUN & !redirect_valid & (count + inflight_q - pop) < 2, where pop = out_valid & out_ready.
REQ-018 On issue, the block SHALL advance fetch_pc by 4 (modulo 2^32), set inflight_q=1, and set inflight_pc to the old fetch_pc; otherwise inflight_q SHALL be cleared.
REQ-019 When inflight_q=1 and there is no redirect, the block SHALL push {inflight_pc, imem_data, 0} into the FIFO at the next edge.
REQ-020 Before issue, fetch_pc SHALL be checked: it is illegal if below MEM_BASE, at or above the range end, or if fetch_pc[1:0]!=0.
REQ-021 On an illegal address in RUN, the block SHALL NOT issue.
REQ-022 On an illegal address in RUN, it SHALL push {fetch_pc, 32'h0000_0000, 1} once FIFO space is available (count - pop < 2 and no in-flight), then enter HALT.
REQ-023 In HALT, there SHALL be no issue and no fault push; the FIFO drains normally; only a redirect leaves HALT.
REQ-024 out_valid = (count!=0) & !redirect_valid; out_pc, out_instr and out_fault SHALL present the FIFO head.
REQ-025 Redirect (highest priority) SHALL empty the FIFO and discard any in-flight response.
REQ-026 Redirect SHALL load fetch_pc=redirect_pc, set state=RUN, and suppress any pop that cycle; issue resumes the following cycle.
REQ-027 Simultaneous push and pop SHALL leave count unchanged, with FIFO order preserved.
REQ-028 The FIFO SHALL never overflow; a push when count==2 without a pop is a design error and the bench SHALL assert against it.
REQ-029 Latency: the first out_valid SHALL rise after the 2nd rising edge following rst deassertion; sustained throughput with out_ready=1 is one instruction per cycle.
REQ-030 If out_ready=0, at most 2 instructions SHALL be buffered and issue SHALL stall; on out_ready=1 the fetch stream SHALL resume with no loss and no duplication.

Reset
REQ-031 While rst=1: fetch_pc=RESET_PC, inflight_q=0, count=0, state=RUN, out_valid=0, out_fault=0; out_pc/out_instr are don't-care.
REQ-032 Assertion of rst mid-operation SHALL immediately abort in-flight and buffered fetches; no stale entry SHALL appear after release.

Verification
REQ-033 Reset release, out_ready=1, imem holding 0x00000013 at words 0..3 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, first valid after 2nd edge.
REQ-034 Hold out_ready=0 for 5 cycles, then 1 -> out_valid stays high with out_pc=0x80000000; no more than 2 entries buffered; on release, PCs continue 0x80000004, 0x80000008 with no gaps.
REQ-035 Pulse redirect_valid with redirect_pc=0x80000040 while the FIFO is full -> out_valid=0 in that cycle; the next delivered out_pc=0x80000040; no 0x8000000x entry appears after the redirect.
REQ-036 Redirect to 0x80000400 (one past end) -> exactly one entry {pc=0x80000400, instr=0, fault=1}, then HALT with no further entries; redirect to 0x80000000 -> normal stream resumes.
REQ-037 Redirect to 0x80000002 (misaligned) and to 0x00000000 -> each yields a single fault entry with out_fault=1.
REQ-038 Assert rst for 1 cycle mid-stream with 2 entries buffered -> out_valid=0 during reset; first post-reset out_pc=0x80000000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: issues PCs to a synchronous-read imem and buffers
// returned words in a 2-entry FIFO toward decode, with redirect and illegal-fetch fault handling.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | issuing sequential fetches, checking each PC before issue
// HALT  | fault entry pushed; no issue until a redirect arrives
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
   parameter int          MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_fault
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   // 33-bit so a range ending exactly at 2^32 does not wrap
   localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + 33'(MEM_WORDS) * 33'd4;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc;
   logic        inflight_q;
   logic [31:0] inflight_pc;
   logic [31:0] pc_q    [2];
   logic [31:0] instr_q [2];
   logic        fault_q [2];
   logic [1:0]  count_q;

   logic        illegal;
   logic        pop;
   logic        issue;
   logic        push_data;
   logic        push_fault;
   logic        push;
   logic [2:0]  occ;
   logic [1:0]  wr_sel;
   logic [1:0]  count_nxt;
   logic [31:0] push_pc;
   logic [31:0] push_instr;

   assign imem_addr = fetch_pc;
   assign illegal   = ({1'b0, fetch_pc} < {1'b0, MEM_BASE}) ||
                      ({1'b0, fetch_pc} >= MEM_END) ||
                      (fetch_pc[1:0] != 2'b00);

   assign out_pc    = pc_q[0];
   assign out_instr = instr_q[0];
   assign out_fault = (count_q != 2'd0) & fault_q[0];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (redirect_valid)  state_d = RUN;
      else if (push_fault) state_d = HALT;
   end

   // Output / control logic
   always_comb begin
      out_valid  = (count_q != 2'd0) & ~redirect_valid;
      pop        = out_valid & out_ready;
      occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      wr_sel     = count_q - {1'b0, pop};
      issue      = 1'b0;
      push_fault = 1'b0;
      push_data  = inflight_q & ~redirect_valid;
      if (state_q == RUN && !redirect_valid) begin
         if (!illegal)
            issue = (occ < 3'd2);
         else
            push_fault = ~inflight_q & (wr_sel < 2'd2);
      end
      push       = push_data | push_fault;
      push_pc    = push_fault ? fetch_pc : inflight_pc;
      push_instr = push_fault ? 32'h0000_0000 : imem_data;
      count_nxt  = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight_q  <= 1'b0;
         inflight_pc <= 32'h0000_0000;
      end else begin
         inflight_q <= issue;
         if (issue) inflight_pc <= fetch_pc;
         if (redirect_valid) fetch_pc <= redirect_pc;
         else if (issue)     fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Shift FIFO: entry 0 is the head; a push lands behind whatever survives the pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            pc_q[i]    <= 32'h0000_0000;
            instr_q[i] <= 32'h0000_0000;
            fault_q[i] <= 1'b0;
         end
      end else if (redirect_valid) begin
         count_q <= 2'd0;
      end else begin
         if (pop) begin
            pc_q[0]    <= pc_q[1];
            instr_q[0] <= instr_q[1];
            fault_q[0] <= fault_q[1];
         end
         if (push) begin
            pc_q[wr_sel[0]]    <= push_pc;
            instr_q[wr_sel[0]] <= push_instr;
            fault_q[wr_sel[0]] <= push_fault;
         end
         count_q <= count_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected fetch entries are queued when reset or a
// redirect is driven, and popped/compared on every accepted transfer.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   int checks = 0;
   int failures = 0;
   int delivered = 0;
   int d0;
   int lat;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } ent_t;
   ent_t exp_q[$];

   fetch_ctrl dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] idx;
      idx = (a - 32'h8000_0000) >> 2;
      if (idx < 32'd4) return 32'h0000_0013;
      return {idx[15:0], 16'h0093};
   endfunction

   function automatic logic is_legal(input logic [31:0] a);
      return (a >= 32'h8000_0000) && (a < 32'h8000_0400) && (a[1:0] == 2'b00);
   endfunction

   always @(posedge clk) imem_data <= mem_word(imem_addr);

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_stream(input logic [31:0] start, input int n);
      ent_t e;
      logic [31:0] pc;
      exp_q.delete();
      pc = start;
      for (int i = 0; i < n; i++) begin
         if (is_legal(pc)) begin
            e.pc = pc; e.instr = mem_word(pc); e.fault = 1'b0;
            exp_q.push_back(e);
            pc = pc + 32'd4;
         end else begin
            e.pc = pc; e.instr = 32'h0; e.fault = 1'b1;
            exp_q.push_back(e);
            break;
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; leaves redirect asserted for exactly one edge.
   task automatic do_redirect(input logic [31:0] target);
      expect_stream(target, 64);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(negedge clk);
      chk("redirect_out_valid", 65'(out_valid), 65'd0);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   // Transfer monitor and overflow watch
   always @(negedge clk) begin
      if (!rst) begin
         chk("no_overflow", 65'(dut.push & ~dut.pop & (dut.count_q == 2'd2)), 65'd0);
         if (out_valid && out_ready) begin
            ent_t e;
            delivered++;
            if (exp_q.size() == 0) begin
               chk("unexpected_entry", {out_fault, out_pc, out_instr}, 65'd0);
            end else begin
               e = exp_q.pop_front();
               chk("entry", {out_fault, out_pc, out_instr}, {e.fault, e.pc, e.instr});
            end
         end
      end
   end

   initial begin
      step(3);
      @(negedge clk);
      chk("rst_out_valid", 65'(out_valid), 65'd0);
      chk("rst_out_fault", 65'(out_fault), 65'd0);
      chk("rst_imem_addr", 65'(imem_addr), 65'(RESET_PC));
      @(posedge clk);
      #1;

      // Reset release, decode stalled: first valid after the 2nd edge
      expect_stream(RESET_PC, 64);
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) break;
      end
      chk("first_valid_latency", 65'(lat), 65'd2);

      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", 65'(out_valid), 65'd1);
         chk("stall_pc", 65'(out_pc), 65'h8000_0000);
         chk("stall_depth", 65'(dut.count_q), 65'd2);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      d0 = delivered;
      step(8);
      chk("throughput", 65'(delivered - d0), 65'd8);

      // Redirect while full
      out_ready = 1'b0;
      step(4);
      @(negedge clk);
      chk("full_before_redirect", 65'(dut.count_q), 65'd2);
      @(posedge clk);
      #1;
      do_redirect(32'h8000_0040);
      out_ready = 1'b1;
      d0 = delivered;
      step(6);
      chk("redirect_resume_count", 65'(delivered - d0), 65'd4);

      // One past the end: single fault then halt
      do_redirect(32'h8000_0400);
      d0 = delivered;
      step(10);
      chk("end_fault_count", 65'(delivered - d0), 65'd1);
      @(negedge clk);
      chk("halt_idle", 65'(out_valid), 65'd0);
      @(posedge clk);
      #1;

      do_redirect(32'h8000_0000);
      d0 = delivered;
      step(6);
      chk("halt_exit_count", 65'(delivered - d0), 65'd4);

      do_redirect(32'h8000_0002);
      d0 = delivered;
      step(8);
      chk("misaligned_fault_count", 65'(delivered - d0), 65'd1);

      do_redirect(32'h0000_0000);
      d0 = delivered;
      step(8);
      chk("low_fault_count", 65'(delivered - d0), 65'd1);

      do_redirect(32'h8000_03FC);
      d0 = delivered;
      step(10);
      chk("last_word_count", 65'(delivered - d0), 65'd2);

      // Mid-stream reset with two entries buffered
      out_ready = 1'b0;
      do_redirect(32'h8000_0000);
      step(5);
      @(negedge clk);
      chk("buffered_before_rst", 65'(dut.count_q), 65'd2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      expect_stream(RESET_PC, 64);
      @(negedge clk);
      chk("mid_rst_out_valid", 65'(out_valid), 65'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      d0 = delivered;
      step(10);
      chk("post_rst_count", 65'(delivered - d0), 65'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
